// File: rtl/rv64_pipelined_core.sv
// Five-stage RV64I-subset core (add/sub/and/or/addi/ld/sd/beq) with internal ROM and RAM.
// EX/MEM and MEM/WB forwarding into EX, one-cycle load-use stall, beq resolved in MEM.

module rv64_regfile #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      wa,
    input  logic            we,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] array [32];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) array[i] <= '0;
        end else if (we && wa != 5'd0) begin
            array[wa] <= wd;
        end
    end

    // write-through so an instruction in ID sees the value being retired this cycle
    always_comb begin
        rd1 = (rs1 == 5'd0) ? '0 : (we && wa == rs1) ? wd : array[rs1];
        rd2 = (rs2 == 5'd0) ? '0 : (we && wa == rs2) ? wd : array[rs2];
    end
endmodule

module rv64_pipelined_core #(
    parameter int                      IMEM_BYTES = 128,
    parameter int                      DMEM_BYTES = 64,
    parameter int                      XLEN       = 64,
    parameter logic [IMEM_BYTES*8-1:0] IMEM_INIT  = '0
) (
    input logic clk,
    input logic reset
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam int IA = $clog2(IMEM_BYTES);
    localparam int DA = $clog2(DMEM_BYTES);

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      f3;
        logic            f7b5;
    } id_ex_t;

    typedef struct packed {
        logic            branch;
        logic            mem_to_reg;
        logic            mem_write;
        logic            reg_write;
        logic            zero;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] store;
        logic [4:0]      rd;
    } ex_mem_t;

    typedef struct packed {
        logic            mem_to_reg;
        logic            reg_write;
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] alu;
        logic [4:0]      rd;
    } mem_wb_t;

    logic [XLEN-1:0] PC_out;
    logic [31:0]     Instruction;
    if_id_t          if_id;
    id_ex_t          id_ex;
    ex_mem_t         ex_mem;
    mem_wb_t         mem_wb;
    logic            PC_Write, IF_ID_Write, control_mux_selector_bit, pc_src;
    logic [1:0]      ForwardA, ForwardB;
    logic [XLEN-1:0] ForwardA_out, ForwardB_out, alu_b, alu_result, write_data;
    logic [4:0]      ID_EX_RS1, ID_EX_RS2, ID_EX_RD, EX_MEM_RD, MEM_WB_RD;
    logic [XLEN-1:0] w0, w1, w2, w3, w4, w5, w6, w7, mem_read_data;
    logic [DA-4:0]   dmem_idx;

    // fetch: out-of-range or misaligned PC reads as a NOP
    logic [IA+2:0] imem_bit;
    assign imem_bit = {PC_out[IA-1:2], 5'b0};
    always_comb begin
        Instruction = 32'h0;
        if (PC_out[XLEN-1:IA] == '0 && PC_out[1:0] == 2'b00)
            Instruction = IMEM_INIT[imem_bit +: 32];
    end

    logic [6:0] id_op, id_f7;
    logic [2:0] id_f3;
    logic [4:0] id_rs1, id_rs2, id_rd;
    ctrl_t      id_ctrl;
    logic [XLEN-1:0] id_imm, id_rd1, id_rd2;

    assign id_op  = if_id.instr[6:0];
    assign id_rd  = if_id.instr[11:7];
    assign id_f3  = if_id.instr[14:12];
    assign id_rs1 = if_id.instr[19:15];
    assign id_rs2 = if_id.instr[24:20];
    assign id_f7  = if_id.instr[31:25];

    always_comb begin
        id_ctrl = '0;
        case (id_op)
            OP_R: if ((id_f3 == 3'b000 && (id_f7 == 7'h00 || id_f7 == 7'h20)) ||
                      ((id_f3 == 3'b111 || id_f3 == 3'b110) && id_f7 == 7'h00)) begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.alu_op    = 2'b10;
            end
            OP_I: if (id_f3 == 3'b000) begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.reg_write = 1'b1;
            end
            OP_LD: if (id_f3 == 3'b011) begin
                id_ctrl.alu_src    = 1'b1;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.reg_write  = 1'b1;
            end
            OP_SD: if (id_f3 == 3'b011) begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: if (id_f3 == 3'b000) begin
                id_ctrl.branch = 1'b1;
                id_ctrl.alu_op = 2'b01;
            end
            default: ;
        endcase
    end

    // SB immediate is kept in halfword units; EX shifts it when forming the target
    always_comb begin
        id_imm = '0;
        case (id_op)
            OP_I, OP_LD: id_imm = {{(XLEN-12){if_id.instr[31]}}, if_id.instr[31:20]};
            OP_SD:       id_imm = {{(XLEN-12){if_id.instr[31]}}, if_id.instr[31:25], if_id.instr[11:7]};
            OP_BEQ:      id_imm = {{(XLEN-12){if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
                                   if_id.instr[30:25], if_id.instr[11:8]};
            default: ;
        endcase
    end

    assign control_mux_selector_bit = id_ex.ctrl.mem_read && id_ex.rd != 5'd0 &&
                                      (id_ex.rd == id_rs1 || id_ex.rd == id_rs2);
    assign PC_Write    = !control_mux_selector_bit;
    assign IF_ID_Write = !control_mux_selector_bit;

    rv64_regfile #(.XLEN(XLEN)) Registers (
        .clk (clk),
        .reset (reset),
        .rs1 (id_rs1),
        .rs2 (id_rs2),
        .wa  (mem_wb.rd),
        .we  (mem_wb.reg_write),
        .wd  (write_data),
        .rd1 (id_rd1),
        .rd2 (id_rd2)
    );

    assign ID_EX_RS1 = id_ex.rs1;
    assign ID_EX_RS2 = id_ex.rs2;
    assign ID_EX_RD  = id_ex.rd;
    assign EX_MEM_RD = ex_mem.rd;
    assign MEM_WB_RD = mem_wb.rd;

    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1)      ForwardA = 2'b10;
        else if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1) ForwardA = 2'b01;
        if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2)      ForwardB = 2'b10;
        else if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2) ForwardB = 2'b01;
    end

    always_comb begin
        case (ForwardA)
            2'b10:   ForwardA_out = ex_mem.alu;
            2'b01:   ForwardA_out = write_data;
            default: ForwardA_out = id_ex.rd1;
        endcase
        case (ForwardB)
            2'b10:   ForwardB_out = ex_mem.alu;
            2'b01:   ForwardB_out = write_data;
            default: ForwardB_out = id_ex.rd2;
        endcase
    end

    assign alu_b = id_ex.ctrl.alu_src ? id_ex.imm : ForwardB_out;

    always_comb begin
        alu_result = ForwardA_out + alu_b;
        case (id_ex.ctrl.alu_op)
            2'b01: alu_result = ForwardA_out - alu_b;
            2'b10: case (id_ex.f3)
                3'b000:  if (id_ex.f7b5) alu_result = ForwardA_out - alu_b;
                3'b111:  alu_result = ForwardA_out & alu_b;
                3'b110:  alu_result = ForwardA_out | alu_b;
                default: ;
            endcase
            default: ;
        endcase
    end

    // data RAM: doubleword k lives in wk; not cleared by reset
    assign dmem_idx = ex_mem.alu[DA-1:3];
    always_ff @(posedge clk) begin
        if (ex_mem.mem_write) begin
            case (dmem_idx)
                3'd0: w0 <= ex_mem.store;
                3'd1: w1 <= ex_mem.store;
                3'd2: w2 <= ex_mem.store;
                3'd3: w3 <= ex_mem.store;
                3'd4: w4 <= ex_mem.store;
                3'd5: w5 <= ex_mem.store;
                3'd6: w6 <= ex_mem.store;
                3'd7: w7 <= ex_mem.store;
            endcase
        end
    end

    always_comb begin
        case (dmem_idx)
            3'd0: mem_read_data = w0;
            3'd1: mem_read_data = w1;
            3'd2: mem_read_data = w2;
            3'd3: mem_read_data = w3;
            3'd4: mem_read_data = w4;
            3'd5: mem_read_data = w5;
            3'd6: mem_read_data = w6;
            3'd7: mem_read_data = w7;
        endcase
    end

    assign pc_src     = ex_mem.branch && ex_mem.zero;
    assign write_data = mem_wb.mem_to_reg ? mem_wb.rdata : mem_wb.alu;

    // a taken branch flushes the three younger stages and beats a pending stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            PC_out <= '0;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            if (pc_src)        PC_out <= ex_mem.target;
            else if (PC_Write) PC_out <= PC_out + XLEN'(4);

            if (pc_src)           if_id <= '0;
            else if (IF_ID_Write) if_id <= '{pc: PC_out, instr: Instruction};

            if (pc_src) begin
                id_ex <= '0;
            end else begin
                id_ex.ctrl <= control_mux_selector_bit ? '0 : id_ctrl;
                id_ex.pc   <= if_id.pc;
                id_ex.rd1  <= id_rd1;
                id_ex.rd2  <= id_rd2;
                id_ex.imm  <= id_imm;
                id_ex.rs1  <= id_rs1;
                id_ex.rs2  <= id_rs2;
                id_ex.rd   <= id_rd;
                id_ex.f3   <= id_f3;
                id_ex.f7b5 <= id_f7[5];
            end

            if (pc_src) begin
                ex_mem <= '0;
            end else begin
                ex_mem.branch     <= id_ex.ctrl.branch;
                ex_mem.mem_to_reg <= id_ex.ctrl.mem_to_reg;
                ex_mem.mem_write  <= id_ex.ctrl.mem_write;
                ex_mem.reg_write  <= id_ex.ctrl.reg_write;
                ex_mem.zero       <= (alu_result == '0);
                ex_mem.target     <= id_ex.pc + (id_ex.imm << 1);
                ex_mem.alu        <= alu_result;
                ex_mem.store      <= ForwardB_out;
                ex_mem.rd         <= id_ex.rd;
            end

            mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
            mem_wb.reg_write  <= ex_mem.reg_write;
            mem_wb.rdata      <= mem_read_data;
            mem_wb.alu        <= ex_mem.alu;
            mem_wb.rd         <= ex_mem.rd;
        end
    end
endmodule

// File: tb/tb_rv64_pipelined_core.sv
// Directed program run on rv64_pipelined_core; pipeline state probed hierarchically.
module tb_rv64_pipelined_core;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;

    // word k at bits [32k+31:32k]
    localparam logic [1023:0] PROG = {352'h0,
        32'h00903823,  // 20 sd   x9,16(x0)
        32'h00300613,  // 19 addi x12,x0,3
        32'h00408463,  // 18 beq  x1,x4,+8 (not taken)
        32'h005265B3,  // 17 or   x11,x4,x5
        32'h00527533,  // 16 and  x10,x4,x5
        32'h404404B3,  // 15 sub  x9,x8,x4
        32'h00900413,  // 14 addi x8,x0,9   (branch target, pc 52)
        32'h00100393,  // 13 addi x7,x0,1   (flushed)
        32'h00100313,  // 12 addi x6,x0,1   (flushed)
        32'h00000663,  // 11 beq  x0,x0,+12
        32'h002101B3,  // 10 add  x3,x2,x2
        32'h00803103,  //  9 ld   x2,8(x0)
        32'h00803083,  //  8 ld   x1,8(x0)
        32'h00503423,  //  7 sd   x5,8(x0)
        32'h02A00293,  //  6 addi x5,x0,42
        32'h00318233,  //  5 add  x4,x3,x3
        32'h00000013,  //  4 nop
        32'h00700193,  //  3 addi x3,x0,7
        32'h00308113,  //  2 addi x2,x1,3
        32'h00500093}; //  1 addi x1,x0,5

    rv64_pipelined_core #(.IMEM_INIT(PROG)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic run_to(input int k);
        while (n < k) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        chk("rst_pc", dut.PC_out, 64'd0);
        chk("rst_fwda", {62'd0, dut.ForwardA}, 64'd0);
        chk("rst_fwdb", {62'd0, dut.ForwardB}, 64'd0);
        chk("rst_idex_rd", {59'd0, dut.ID_EX_RD}, 64'd0);
        for (int i = 1; i < 32; i++)
            chk($sformatf("rst_x%0d", i), dut.Registers.array[i], 64'd0);

        reset = 1'b1;
        n = 0;
        tick();
        chk("e1_pc", dut.PC_out, 64'd4);
        chk("e1_instr", {32'd0, dut.Instruction}, 64'h00308113);

        run_to(3);
        chk("exex_fwda", {62'd0, dut.ForwardA}, 64'd2);
        chk("exex_rs1", {59'd0, dut.ID_EX_RS1}, 64'd1);
        chk("exex_rd", {59'd0, dut.ID_EX_RD}, 64'd2);
        chk("exex_a_out", dut.ForwardA_out, 64'd5);

        run_to(6);
        chk("memex_fwda", {62'd0, dut.ForwardA}, 64'd1);
        chk("memex_fwdb", {62'd0, dut.ForwardB}, 64'd1);
        chk("memex_b_out", dut.ForwardB_out, 64'd7);
        chk("x2_eq_8", dut.Registers.array[2], 64'd8);

        run_to(8);
        chk("sd_fwdb", {62'd0, dut.ForwardB}, 64'd2);
        chk("sd_fwda", {62'd0, dut.ForwardA}, 64'd0);
        chk("sd_data", dut.ForwardB_out, 64'd42);

        run_to(10);
        chk("stall_pcw", {63'd0, dut.PC_Write}, 64'd0);
        chk("stall_ifidw", {63'd0, dut.IF_ID_Write}, 64'd0);
        chk("stall_sel", {63'd0, dut.control_mux_selector_bit}, 64'd1);
        chk("stall_pc", dut.PC_out, 64'd40);
        chk("x4_eq_14", dut.Registers.array[4], 64'd14);

        run_to(11);
        chk("held_pc", dut.PC_out, 64'd40);
        chk("unstall_sel", {63'd0, dut.control_mux_selector_bit}, 64'd0);

        run_to(12);
        chk("ldu_fwda", {62'd0, dut.ForwardA}, 64'd1);
        chk("ldu_fwdb", {62'd0, dut.ForwardB}, 64'd1);
        chk("ldu_memwb_rd", {59'd0, dut.MEM_WB_RD}, 64'd2);
        chk("ldu_a_out", dut.ForwardA_out, 64'd42);
        chk("x1_eq_42", dut.Registers.array[1], 64'd42);
        chk("w1_eq_42", dut.w1, 64'd42);

        run_to(15);
        chk("br_pc", dut.PC_out, 64'd52);
        chk("br_instr", {32'd0, dut.Instruction}, 64'h00900413);
        chk("br_flush_idex", {59'd0, dut.ID_EX_RD}, 64'd0);
        chk("br_flush_exmem", {59'd0, dut.EX_MEM_RD}, 64'd0);

        run_to(16);
        chk("br_pc_next", dut.PC_out, 64'd56);

        run_to(40);
        chk("x1", dut.Registers.array[1], 64'd42);
        chk("x2", dut.Registers.array[2], 64'd42);
        chk("x3", dut.Registers.array[3], 64'd84);
        chk("x5", dut.Registers.array[5], 64'd42);
        chk("x6_flushed", dut.Registers.array[6], 64'd0);
        chk("x7_flushed", dut.Registers.array[7], 64'd0);
        chk("x8", dut.Registers.array[8], 64'd9);
        chk("x9_sub", dut.Registers.array[9], 64'hFFFF_FFFF_FFFF_FFFB);
        chk("x10_and", dut.Registers.array[10], 64'd10);
        chk("x11_or", dut.Registers.array[11], 64'd46);
        chk("x12_not_taken", dut.Registers.array[12], 64'd3);
        chk("w2_neg", dut.w2, 64'hFFFF_FFFF_FFFF_FFFB);

        reset = 1'b0;
        tick();
        chk("mid_rst_pc", dut.PC_out, 64'd0);
        chk("mid_rst_x3", dut.Registers.array[3], 64'd0);
        chk("mid_rst_x9", dut.Registers.array[9], 64'd0);
        chk("mid_rst_memwb", {59'd0, dut.MEM_WB_RD}, 64'd0);
        chk("mid_rst_w1_kept", dut.w1, 64'd42);
        chk("mid_rst_w2_kept", dut.w2, 64'hFFFF_FFFF_FFFF_FFFB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
